pc_seq_ctrl: RTL

- Sequencer for the next-PC datapath in the single-cycle processor.
- Owns the architectural PC register and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the latched instruction to the datapath and drives its UncondBr/BrTaken selects from execute-stage branch outcome.
- Loads the datapath's computed next PC when the instruction retires; also detects fetch timeout, misaligned PC and halt.

---
 rtl/pc_seq_ctrl_if.sv | 11 +
 rtl/pc_seq_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl_if.sv
// Instruction-memory fetch channel between the PC sequencer (master) and imem (slave).
// A request holds while imem_req=1; the cycle with imem_ack=1 carries imem_instr.
interface pc_seq_ctrl_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_instr;

  modport master (output imem_req, imem_addr, input imem_ack, imem_instr);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_instr);
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: fetch over req/ack, latch the instruction, retire by loading pc_next.
// Minimum 2 cycles/instruction; stall or missing ex_done holds EXEC, missing ack times out to ERR.
module pc_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset,
  pc_seq_ctrl_if.master imem,
  output logic [31:0]   instruction,
  output logic          instr_valid,
  output logic [63:0]   pc,
  input  logic [63:0]   pc_next,
  input  logic          ex_done,
  input  logic          ex_uncond,
  input  logic          ex_cond,
  input  logic          ex_flag,
  input  logic          ex_halt,
  input  logic          stall,
  output logic          UncondBr,
  output logic          BrTaken,
  output logic [31:0]   retired,
  output logic          halted,
  output logic          fetch_err,
  output logic          align_err
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT, ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt, tmo_cnt_nxt;
  logic [63:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] retired_nxt;
  logic        fetch_err_nxt, align_err_nxt;
  logic        retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      tmo_cnt     <= 8'd0;
      pc          <= RESET_PC;
      instruction <= 32'd0;
      retired     <= 32'd0;
      fetch_err   <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      retired     <= retired_nxt;
      fetch_err   <= fetch_err_nxt;
      align_err   <= align_err_nxt;
    end
  end

  assign retire = ex_done & ~stall;

  always_comb begin
    state_nxt     = state;
    tmo_cnt_nxt   = tmo_cnt;
    pc_nxt        = pc;
    instr_nxt     = instruction;
    retired_nxt   = retired;
    fetch_err_nxt = fetch_err;
    align_err_nxt = align_err;
    case (state)
      FETCH: begin
        // Ack wins over timeout, so an ack on the last allowed cycle is still taken.
        if (imem.imem_ack) begin
          instr_nxt   = imem.imem_instr;
          tmo_cnt_nxt = 8'd0;
          state_nxt   = EXEC;
        end else if (tmo_cnt == TMO_LAST) begin
          fetch_err_nxt = 1'b1;
          state_nxt     = ERR;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      EXEC: begin
        if (retire) begin
          if (ex_halt) begin
            retired_nxt = retired + 32'd1;
            state_nxt   = HALT;
          end else if (pc_next[1:0] != 2'b00) begin
            align_err_nxt = 1'b1;
            state_nxt     = ERR;
          end else begin
            pc_nxt      = pc_next;
            retired_nxt = retired + 32'd1;
            state_nxt   = FETCH;
          end
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Request is gated by reset so it drops the moment reset asserts, not at the next edge.
  assign imem.imem_req  = reset & (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);
  assign halted         = (state == HALT);
  assign UncondBr       = instr_valid & ex_uncond;
  assign BrTaken        = instr_valid & (ex_uncond | (ex_cond & ex_flag));

endmodule
